// File: rtl/burst_detect_nch_pkg.sv
// Shared definitions for the burst detector: FSM state type, burst length
// encoding and the default no-cross boundary.
package burst_detect_nch_pkg;

    // IDLE: no burst under construction; OPEN: base address and length valid
    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    // Burst length travels as beats-1, so a stored len of 0 means one beat
    localparam int LEN_BEATS_OFFSET = 1;

    // Bursts never cross a 4 KiB boundary unless overridden
    localparam int BOUNDARY_LOG_DEFAULT = 12;

endpackage

// File: rtl/burst_detect_stats.sv
// Saturating statistics counters for emitted bursts and the beats they carry.
// Only instantiated when BURST_DETECT_STATS_EN is defined.
module burst_detect_stats
    import burst_detect_nch_pkg::*;
#(
    parameter int BurstLenWidth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [BurstLenWidth-1:0] i_len,
    output logic [31:0]              o_statBursts,
    output logic [31:0]              o_statBeats
);

    logic [31:0] r_bursts;
    logic [31:0] r_beats;
    logic [32:0] w_beatsSum;

    // One extra bit on the sum exposes overflow so the beat counter can clamp
    always_comb begin
        w_beatsSum = {1'b0, r_beats} + 33'(i_len) + 33'(LEN_BEATS_OFFSET);
    end

    // Count each push and its beats, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bursts <= '0;
            r_beats  <= '0;
        end else if (i_push) begin
            if (r_bursts != '1) begin
                r_bursts <= r_bursts + 32'd1;
            end
            if (w_beatsSum[32]) begin
                r_beats <= '1;
            end else begin
                r_beats <= w_beatsSum[31:0];
            end
        end
    end

    assign o_statBursts = r_bursts;
    assign o_statBeats  = r_beats;

endmodule

// File: rtl/burst_detect_nch.sv
// Burst detector: merges a stream of beat addresses into {len, base} bursts
// and fans the burst length out to NumLenOut length FIFOs.
// Optional macro BURST_DETECT_STATS_EN adds stat_bursts / stat_beats outputs.
module burst_detect_nch
    import burst_detect_nch_pkg::*;
#(
    parameter int AddrWidth         = 64,
    parameter int DataWidthBytesLog = 6,
    parameter int WaitTimeWidth     = 4,
    parameter int BurstLenWidth     = 8,
    parameter int NumLenOut         = 2,
    parameter int BoundaryLog       = BOUNDARY_LOG_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WaitTimeWidth-1:0]            max_wait_time,
    input  logic [BurstLenWidth-1:0]            max_burst_len,
    input  logic                                flush,
    input  logic [AddrWidth-1:0]                addr_dout,
    input  logic                                addr_empty_n,
    output logic                                addr_read,
    output logic [BurstLenWidth+AddrWidth-1:0]  addr_din,
    input  logic                                addr_full_n,
    output logic                                addr_write,
    output logic [NumLenOut*BurstLenWidth-1:0]  len_din,
    input  logic [NumLenOut-1:0]                len_full_n,
    output logic [NumLenOut-1:0]                len_write,
    output logic                                busy
`ifdef BURST_DETECT_STATS_EN
    ,
    output logic [31:0]                         stat_bursts,
    output logic [31:0]                         stat_beats
`endif
);

    localparam int BeatWidth = AddrWidth - DataWidthBytesLog;

    state_t                   r_state;
    logic [AddrWidth-1:0]     r_baseAddr;
    logic [BurstLenWidth-1:0] r_len;
    logic [WaitTimeWidth-1:0] r_wait;
    logic [AddrWidth-1:0]     r_inQ;
    logic                     r_inV;

    state_t                   w_nextState;
    logic [AddrWidth-1:0]     w_nextBase;
    logic [BurstLenWidth-1:0] w_nextLen;
    logic [WaitTimeWidth-1:0] w_nextWait;
    logic                     w_push;
    logic                     w_outReady;
    logic [BeatWidth-1:0]     w_nextBeat;
    logic                     w_merge;

    // A push must land in the address FIFO and every length FIFO at once
    assign w_outReady = addr_full_n & (&len_full_n);

    // Pop whenever data is waiting and the output side can absorb progress
    assign addr_read = w_outReady & addr_empty_n & ~rst;

    // Input register: captures the popped address; only advances when output is ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inV <= 1'b0;
            r_inQ <= '0;
        end else if (w_outReady) begin
            r_inV <= addr_empty_n;
            if (addr_empty_n) begin
                r_inQ <= addr_dout;
            end
        end
    end

    // Beat that would extend the open burst, wrapping across the address space
    assign w_nextBeat = r_baseAddr[AddrWidth-1:DataWidthBytesLog]
                      + BeatWidth'(r_len) + BeatWidth'(1);

    // Merge only contiguous beats that do not start a new boundary window and fit the length cap
    assign w_merge = (r_inQ[AddrWidth-1:DataWidthBytesLog] == w_nextBeat)
                   && (r_inQ[BoundaryLog-1:0] != '0)
                   && (r_len < max_burst_len);

    // Next-state and push decision; everything holds while the output is stalled
    always_comb begin
        w_nextState = r_state;
        w_nextBase  = r_baseAddr;
        w_nextLen   = r_len;
        w_nextWait  = r_wait;
        w_push      = 1'b0;
        if (w_outReady) begin
            unique case (r_state)
                IDLE: begin
                    if (r_inV) begin
                        w_nextBase  = r_inQ;
                        w_nextLen   = '0;
                        w_nextWait  = '0;
                        w_nextState = OPEN;
                    end
                end
                OPEN: begin
                    if (flush) begin
                        w_push     = 1'b1;
                        w_nextWait = '0;
                        if (r_inV) begin
                            w_nextBase  = r_inQ;
                            w_nextLen   = '0;
                            w_nextState = OPEN;
                        end else begin
                            w_nextState = IDLE;
                        end
                    end else if (r_inV) begin
                        w_nextWait = '0;
                        if (w_merge) begin
                            w_nextLen = r_len + 1'b1;
                        end else begin
                            w_push     = 1'b1;
                            w_nextBase = r_inQ;
                            w_nextLen  = '0;
                        end
                    end else if (r_wait < max_wait_time) begin
                        w_nextWait = r_wait + 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_nextWait  = '0;
                        w_nextState = IDLE;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // Burst state register; reset drops any burst under construction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baseAddr <= '0;
            r_len      <= '0;
            r_wait     <= '0;
        end else begin
            r_state    <= w_nextState;
            r_baseAddr <= w_nextBase;
            r_len      <= w_nextLen;
            r_wait     <= w_nextWait;
        end
    end

    assign addr_write = w_push & ~rst;
    assign len_write  = {NumLenOut{w_push & ~rst}};
    assign addr_din   = {r_len, r_baseAddr};
    assign len_din    = {NumLenOut{r_len}};
    assign busy       = r_inV | (r_state == OPEN);

`ifdef BURST_DETECT_STATS_EN
    burst_detect_stats #(
        .BurstLenWidth (BurstLenWidth)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .i_push       (addr_write),
        .i_len        (r_len),
        .o_statBursts (stat_bursts),
        .o_statBeats  (stat_beats)
    );
`endif

endmodule

// File: doc/burst_detect_nch.md
BURST_DETECT_NCH -- requirements
Module: burst_detect_nch

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, byte-address width.
REQ-002 SHALL have parameter DataWidthBytesLog, default 6, log2 of bytes per beat.
REQ-003 SHALL have parameter WaitTimeWidth, default 4, idle-timeout counter width.
REQ-004 SHALL have parameter BurstLenWidth, default 8, burst length field width (beats-1 encoding).
REQ-005 SHALL have parameter NumLenOut, default 2, number of burst-length fan-out channels (1..8).
REQ-006 SHALL have parameter BoundaryLog, default 12, log2 of the no-cross boundary in bytes.
REQ-007 SHALL have ports, in order:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- max_wait_time  in  WaitTimeWidth  idle cycles before emitting an open burst
- max_burst_len  in  BurstLenWidth  maximum beats-1; 0 disables merging
- flush  in  1  force emission of any open burst
- addr_dout  in  AddrWidth  input address FIFO data
- addr_empty_n  in  1  input FIFO not empty
- addr_read  out  1  input FIFO pop
- addr_din  out  BurstLenWidth+AddrWidth  {len, base_addr}
- addr_full_n  in  1  address output FIFO not full
- addr_write  out  1  address output push
- len_din  out  NumLenOut*BurstLenWidth  replicated len, channel i at slice i
- len_full_n  in  NumLenOut  per-channel not full
- len_write  out  NumLenOut  per-channel push
- busy  out  1  burst open or input register valid

Function
REQ-008 SHALL define out_ready = addr_full_n AND all bits of len_full_n; every push (addr_write, all len_write bits) SHALL occur together and only when out_ready.
REQ-009 SHALL register input: addr_read = out_ready AND addr_empty_n; popped address lands in in_q with in_v=1 next cycle; in_v cleared when out_ready and no pop.
REQ-010 SHALL use states IDLE (no base) and OPEN (base_addr, len valid); when out_ready=0 all state and in_q SHALL hold.
REQ-011 IDLE with in_v: base_addr<=in_q, len<=0, wait<=0, go OPEN, no push.
REQ-012 OPEN with in_v: merge iff in_q beat index == base beat index + len + 1 (NextAddr width, wraps modulo 2^(AddrWidth-DataWidthBytesLog)), in_q[BoundaryLog-1:0] != 0, and len < max_burst_len; merge increments len, wait<=0.
REQ-013 OPEN with in_v and no merge: push {len, base_addr}, base_addr<=in_q, len<=0, stay OPEN.
REQ-014 OPEN without in_v: wait increments while wait < max_wait_time; at equality push, go IDLE, wait<=0.
REQ-015 flush=1 in OPEN: push current burst that cycle (if out_ready); if in_v simultaneously, in_q opens a new burst (OPEN), else go IDLE; flush in IDLE SHALL be no-op.
REQ-016 Address-to-push latency minimum 2 cycles (pop, then register-to-decision); push combinational from state.
REQ-017 busy = in_v OR state==OPEN.

Reset
REQ-018 rst SHALL set state IDLE, base_addr 0, len 0, wait 0, in_v 0; addr_read, addr_write, len_write SHALL be 0 during rst; an open burst at reset SHALL be discarded.

Configuration
REQ-019 Macro BURST_DETECT_STATS_EN SHALL add outputs stat_bursts (32) and stat_beats (32): count pushes and beats (len+1) per push, saturating at all-ones, cleared by rst; without macro these ports and counters SHALL not exist.

Structure
REQ-020 Shared package SHALL hold state enum, len encoding constant (beats-1), and BoundaryLog default.
REQ-021 Sub-module burst_detect_stats SHALL implement the saturating counters, instantiated only under the macro.

Verification
REQ-022 Sequential 0x0,0x40,0x80,0xC0, max_burst_len=255, max_wait=3 -> one push {3,0x0} after 4 idle cycles.
REQ-023 Addresses 0xFC0,0x1000 -> two pushes {0,0xFC0},{0,0x1000} (boundary break).
REQ-024 max_burst_len=0, 0x0,0x40 -> pushes {0,0x0},{0,0x40}.
REQ-025 len_full_n[1]=0 for 10 cycles mid-stream -> no pops, no pushes; stream resumes with identical final output.
REQ-026 0x0,0x40 then flush with 0x200 in in_q -> push {1,0x0}, then {0,0x200} after timeout.
REQ-027 rst asserted while OPEN -> no push; post-reset 0x80 -> {0,0x80}; with BURST_DETECT_STATS_EN, stat_bursts=1, stat_beats=1.
